// File: rtl/demux_route_pkg.sv
// Shared types and constants for the demux_route_ctrl lane sequencer.
package demux_route_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;

  localparam int N_LANES = 16;
  localparam int SEL_W = 4;
  localparam logic [SEL_W-1:0] LAST_LANE = 4'd15;

endpackage

// File: rtl/demux_route_timer.sv
// Per-lane wait counter: counts stalled SEND cycles and flags expiry after TIMEOUT of them.
module demux_route_timer #(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [7:0] LIMIT = 8'(TIMEOUT - 1);

  logic [7:0] cnt_q;
  logic [7:0] cnt_d;

  // Expiry is seen on the stalled cycle that brings the count up to TIMEOUT.
  assign expired = enable && (cnt_q == LIMIT);

  always_comb begin
    cnt_d = cnt_q;
    if (clear || expired) begin
      cnt_d = '0;
    end else if (enable) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/demux_route_ctrl.sv
// Select-line sequencer for the 1-to-16 demux fabric (unicast and broadcast, lane timeout).
// Optional drop counter: define DEMUX_ROUTE_DROP_CNT_EN to add drop_cnt/drop_clr.
module demux_route_ctrl
  import demux_route_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [SEL_W-1:0]  in_dest,
  input  logic              in_bcast,
  output logic [DATA_W-1:0] out_data,
  output logic [N_LANES-1:0] out_valid,
  input  logic [N_LANES-1:0] out_ready,
  output logic [SEL_W-1:0]  select,
  output logic              busy,
`ifdef DEMUX_ROUTE_DROP_CNT_EN
  output logic [7:0]        drop_cnt,
  input  logic              drop_clr,
`endif
  output logic              timeout_pulse
);

  // Handshake contract, both sides: a word moves on a cycle where valid and
  // ready are both high; valid never depends on ready within the same cycle.

  state_e              state_q, state_d;
  logic [SEL_W-1:0]    sel_q, sel_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                bcast_q, bcast_d;
  logic                hs;
  logic                expired;
  logic                timer_en;

  assign hs       = (state_q == SEND) && out_ready[sel_q];
  assign timer_en = (state_q == SEND) && !hs;

  demux_route_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (!timer_en),
    .enable  (timer_en),
    .expired (expired)
  );

  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    data_d    = data_q;
    bcast_d   = bcast_q;
    in_ready  = 1'b0;
    out_valid = '0;
    case (state_q)
      IDLE: begin
        in_ready = !rst;
        if (in_valid && !rst) begin
          data_d  = in_data;
          sel_d   = in_bcast ? '0 : in_dest;
          bcast_d = in_bcast;
          state_d = SEND;
        end
      end
      SEND: begin
        out_valid = {{(N_LANES-1){1'b0}}, 1'b1} << sel_q;
        // A timeout advances the walk exactly like a completed handshake.
        if (hs || expired) begin
          if (bcast_q && (sel_q != LAST_LANE)) begin
            sel_d = sel_q + 4'd1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sel_q   <= '0;
      data_q  <= '0;
      bcast_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      data_q  <= data_d;
      bcast_q <= bcast_d;
    end
  end

  assign out_data      = data_q;
  assign select        = sel_q;
  assign busy          = (state_q != IDLE);
  assign timeout_pulse = expired && !rst;

`ifdef DEMUX_ROUTE_DROP_CNT_EN
  logic [7:0] drop_cnt_q, drop_cnt_d;

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (drop_clr) begin
      drop_cnt_d = '0;
    end else if (timeout_pulse && (drop_cnt_q != 8'hFF)) begin
      drop_cnt_d = drop_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      drop_cnt_q <= '0;
    end else begin
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign drop_cnt = drop_cnt_q;
`endif

endmodule

// File: tb/tb_demux_route_ctrl.sv
// Directed bench for demux_route_ctrl: unicast, broadcast, timeout, reset and drop counter.
module tb_demux_route_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic [3:0]  in_dest;
  logic        in_bcast;
  logic [7:0]  out_data;
  logic [15:0] out_valid;
  logic [15:0] out_ready;
  logic [3:0]  select;
  logic        busy;
  logic        timeout_pulse;
`ifdef DEMUX_ROUTE_DROP_CNT_EN
  logic [7:0]  drop_cnt;
  logic        drop_clr = 1'b0;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  demux_route_ctrl #(.DATA_W(8), .TIMEOUT(15)) dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_data       (in_data),
    .in_dest       (in_dest),
    .in_bcast      (in_bcast),
    .out_data      (out_data),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .select        (select),
    .busy          (busy),
`ifdef DEMUX_ROUTE_DROP_CNT_EN
    .drop_cnt      (drop_cnt),
    .drop_clr      (drop_clr),
`endif
    .timeout_pulse (timeout_pulse)
  );

  // Present one word for one cycle; returns at the negedge of the first SEND cycle.
  task automatic send(input logic [7:0] d, input logic [3:0] dest, input logic bc);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    in_dest  = dest;
    in_bcast = bc;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_dest = '0; in_bcast = 1'b0;
    out_ready = '1;
    repeat (2) @(negedge clk);
    checks++;
    if (in_ready !== 1'b0 || busy !== 1'b0 || out_valid !== 16'h0 || select !== 4'd0 ||
        out_data !== 8'h00 || timeout_pulse !== 1'b0) begin
      errors++;
      $display("FAIL reset_values: in_ready=%b busy=%b out_valid=%h select=%0d out_data=%h pulse=%b expected 0 for all",
               in_ready, busy, out_valid, select, out_data, timeout_pulse);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_idle_ready: in_ready=%b expected 1", in_ready);
    end
  endtask

  task automatic test_unicast();
    out_ready = '1;
    send(8'hA5, 4'd9, 1'b0);
    checks++;
    if (out_valid !== 16'h0200 || select !== 4'd9 || out_data !== 8'hA5 || busy !== 1'b1 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL unicast_send: out_valid=%h select=%0d out_data=%h busy=%b in_ready=%b expected 0200 9 a5 1 0",
               out_valid, select, out_data, busy, in_ready);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || in_ready !== 1'b1 || out_valid !== 16'h0) begin
      errors++;
      $display("FAIL unicast_done: busy=%b in_ready=%b out_valid=%h expected 0 1 0000", busy, in_ready, out_valid);
    end
  endtask

  task automatic test_broadcast();
    logic [15:0] exp_v;
    int bad = 0;
    out_ready = '1;
    send(8'h3C, 4'd6, 1'b1);
    for (int i = 0; i < 16; i++) begin
      exp_v = 16'h1 << i;
      if (out_valid !== exp_v || select !== 4'(i) || timeout_pulse !== 1'b0 || out_data !== 8'h3C) begin
        bad++;
        $display("FAIL bcast_walk lane %0d: out_valid=%h select=%0d pulse=%b data=%h expected %h %0d 0 3c",
                 i, out_valid, select, timeout_pulse, out_data, exp_v, i);
      end
      @(negedge clk);
    end
    checks++;
    if (bad != 0) errors++;
    checks++;
    if (busy !== 1'b0 || out_valid !== 16'h0) begin
      errors++;
      $display("FAIL bcast_done: busy=%b out_valid=%h expected 0 0000", busy, out_valid);
    end
  endtask

  task automatic test_timeout();
    int bad = 0;
    out_ready = ~16'h0010;
    send(8'h5A, 4'd4, 1'b0);
    for (int c = 1; c <= 15; c++) begin
      if (timeout_pulse !== (c == 15) || out_valid !== 16'h0010) begin
        bad++;
        $display("FAIL timeout_cycle %0d: pulse=%b out_valid=%h expected %b 0010",
                 c, timeout_pulse, out_valid, (c == 15));
      end
      @(negedge clk);
    end
    checks++;
    if (bad != 0) errors++;
    checks++;
    if (busy !== 1'b0 || timeout_pulse !== 1'b0) begin
      errors++;
      $display("FAIL timeout_idle: busy=%b pulse=%b expected 0 0", busy, timeout_pulse);
    end
`ifdef DEMUX_ROUTE_DROP_CNT_EN
    checks++;
    if (drop_cnt !== 8'd1) begin
      errors++;
      $display("FAIL timeout_drop_cnt: drop_cnt=%0d expected 1", drop_cnt);
    end
`endif
    out_ready = '1;
  endtask

  // Handshake arriving on the very cycle the count reaches TIMEOUT wins.
  task automatic test_timeout_race();
    out_ready = 16'h0;
    send(8'h66, 4'd3, 1'b0);
    repeat (14) @(negedge clk);
    out_ready = 16'h0008;
    #1;
    checks++;
    if (timeout_pulse !== 1'b0 || out_valid !== 16'h0008) begin
      errors++;
      $display("FAIL race_no_pulse: pulse=%b out_valid=%h expected 0 0008", timeout_pulse, out_valid);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL race_idle: busy=%b expected 0", busy);
    end
`ifdef DEMUX_ROUTE_DROP_CNT_EN
    checks++;
    if (drop_cnt !== 8'd1) begin
      errors++;
      $display("FAIL race_drop_cnt: drop_cnt=%0d expected 1", drop_cnt);
    end
`endif
    out_ready = '1;
  endtask

  task automatic test_bcast_stall();
    logic [15:0] exp_v;
    int bad = 0;
    int pulses = 0;
    int cyc;
    out_ready = ~16'h0080;
    send(8'hC3, 4'd0, 1'b1);
    for (int lane = 0; lane < 16; lane++) begin
      cyc = (lane == 7) ? 15 : 1;
      exp_v = 16'h1 << lane;
      for (int c = 1; c <= cyc; c++) begin
        if (timeout_pulse === 1'b1) pulses++;
        if (out_valid !== exp_v || select !== 4'(lane) || timeout_pulse !== (lane == 7 && c == 15)) begin
          bad++;
          $display("FAIL stall_walk lane %0d cyc %0d: out_valid=%h select=%0d pulse=%b expected %h %0d %b",
                   lane, c, out_valid, select, timeout_pulse, exp_v, lane, (lane == 7 && c == 15));
        end
        @(negedge clk);
      end
    end
    checks++;
    if (bad != 0) errors++;
    checks++;
    if (pulses != 1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL stall_summary: pulses=%0d busy=%b expected 1 0", pulses, busy);
    end
`ifdef DEMUX_ROUTE_DROP_CNT_EN
    checks++;
    if (drop_cnt !== 8'd2) begin
      errors++;
      $display("FAIL stall_drop_cnt: drop_cnt=%0d expected 2", drop_cnt);
    end
`endif
    out_ready = '1;
  endtask

  task automatic test_reset_mid();
    out_ready = '1;
    send(8'h11, 4'd0, 1'b1);
    repeat (5) @(negedge clk);
    checks++;
    if (select !== 4'd5 || out_valid !== 16'h0020) begin
      errors++;
      $display("FAIL mid_pre_reset: select=%0d out_valid=%h expected 5 0020", select, out_valid);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (out_valid !== 16'h0 || select !== 4'd0 || busy !== 1'b0 || out_data !== 8'h00 || timeout_pulse !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: out_valid=%h select=%0d busy=%b out_data=%h pulse=%b expected 0000 0 0 00 0",
               out_valid, select, busy, out_data, timeout_pulse);
    end
    rst = 1'b0;
    send(8'h77, 4'd2, 1'b0);
    checks++;
    if (out_valid !== 16'h0004 || select !== 4'd2 || out_data !== 8'h77) begin
      errors++;
      $display("FAIL mid_unicast: out_valid=%h select=%0d out_data=%h expected 0004 2 77", out_valid, select, out_data);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL mid_unicast_done: busy=%b in_ready=%b expected 0 1", busy, in_ready);
    end
  endtask

`ifdef DEMUX_ROUTE_DROP_CNT_EN
  task automatic test_saturation();
    out_ready = 16'h0;
    for (int k = 0; k < 300; k++) begin
      send(8'h01, 4'd0, 1'b0);
      repeat (15) @(negedge clk);
    end
    checks++;
    if (drop_cnt !== 8'd255 || busy !== 1'b0) begin
      errors++;
      $display("FAIL drop_saturate: drop_cnt=%0d busy=%b expected 255 0", drop_cnt, busy);
    end
    send(8'h02, 4'd1, 1'b0);
    repeat (14) @(negedge clk);
    checks++;
    if (timeout_pulse !== 1'b1) begin
      errors++;
      $display("FAIL drop_clr_pulse: pulse=%b expected 1", timeout_pulse);
    end
    drop_clr = 1'b1;
    @(negedge clk);
    drop_clr = 1'b0;
    checks++;
    if (drop_cnt !== 8'd0) begin
      errors++;
      $display("FAIL drop_clr: drop_cnt=%0d expected 0", drop_cnt);
    end
    out_ready = '1;
  endtask
`endif

  initial begin
    test_reset();
    test_unicast();
    test_broadcast();
    test_timeout();
    test_timeout_race();
    test_bcast_stall();
    test_reset_mid();
`ifdef DEMUX_ROUTE_DROP_CNT_EN
    test_saturation();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/demux_route_ctrl.md
Name: demux_route_ctrl

Overview:
- Sequencer that owns the select lines of the team's 1-to-16 demultiplexer fabric.
- Accepts one word per transaction on a valid/ready input, together with a 4-bit destination or a broadcast flag.
- Presents the word on one of 16 valid/ready output lanes, one lane at a time. Broadcast walks lanes 0..15 in order.
- A per-lane timeout prevents a stalled consumer from locking up the fabric.

Parameters:
- DATA_W, 8, width of the routed data word.
- TIMEOUT, 15, cycles a lane may hold out_ready low before it is skipped (range 1..255).

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  synchronous reset, active-high.
- in_valid  input  1  upstream word available.
- in_ready  output  1  controller accepts word this cycle.
- in_data  input  DATA_W  word to route.
- in_dest  input  4  destination lane (ignored when in_bcast=1).
- in_bcast  input  1  deliver word to all 16 lanes sequentially.
- out_data  output  DATA_W  latched word, shared by all lanes.
- out_valid  output  16  one-hot lane valid; at most one bit set.
- out_ready  input  16  per-lane consumer ready.
- select  output  4  current lane index, drives the demux select inputs.
- busy  output  1  high whenever state != IDLE.
- timeout_pulse  output  1  one-cycle pulse when a lane is skipped.

Behaviour:
- Clocking and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: state=IDLE, select=0, out_data=0, out_valid=0, busy=0, timeout_pulse=0, wait counter=0. in_ready=0 during the reset cycle, then 1 in IDLE.
- State IDLE:
  - in_ready=1, out_valid=0.
  - On in_valid&in_ready: latch in_data into out_data.
  - select <= in_bcast ? 0 : in_dest; latch bcast flag; clear wait counter; go to SEND next cycle.
- State SEND:
  - in_ready=0; out_valid = 1<<select; out_data stable.
- Handshake completes when out_valid[select]&out_ready[select]:
  - Non-broadcast, or broadcast with select==15: go to IDLE. out_valid drops the next cycle.
  - Broadcast with select<15: select++ and clear wait counter. The next lane is valid the following cycle (no idle gap).
- Timeout:
  - The wait counter increments each SEND cycle without a handshake.
  - When it reaches TIMEOUT with no handshake in that cycle, assert timeout_pulse for one cycle.
  - Then advance exactly as for a completed handshake.
  - A handshake in the same cycle the counter hits TIMEOUT counts as success: no pulse.
- Latency: accept in cycle N; out_valid is asserted in cycle N+1. Minimum two cycles per unicast word (in_ready is low during SEND).
- Ready on other lanes: out_ready on lanes other than select is ignored.
- Reset mid-SEND: the transfer is abandoned, all outputs return to reset values next cycle, and no pulse is generated.
- Select width: 4 bits. Broadcast increments never wrap past 15; they terminate at 15.

Optional Feature:
- Macro: DEMUX_ROUTE_DROP_CNT_EN.
- Defined:
  - Adds output drop_cnt[7:0], reset to 0.
  - Increments on each timeout_pulse and saturates at 255 (no wrap).
  - Adds input drop_clr (1 bit): synchronous clear, taking priority over increment in the same cycle.
- Undefined: neither port exists and no counter logic is generated. All other behaviour is identical.

Decomposition:
- Shared package demux_route_pkg holds:
  - State enum: IDLE=1'b0, SEND=1'b1.
  - Localparams N_LANES=16, SEL_W=4, LAST_LANE=4'd15.
- One natural sub-module, demux_route_timer: the wait counter plus compare.
  - Inputs: clk, rst, clear, enable.
  - Output: expired.
  - Parameterised by TIMEOUT.
- The lane one-hot decode stays inline.

Test Plan:
- Unicast: after reset, send in_data=8'hA5, in_dest=4'd9, in_bcast=0, with out_ready all ones.
  - Expect out_valid=16'h0200, select=9 and out_data=8'hA5 one cycle after accept.
  - Expect busy low and in_ready high the cycle after the handshake.
- Broadcast: in_data=8'h3C, in_bcast=1, out_ready all ones.
  - Expect out_valid to walk 16'h0001..16'h8000 over 16 consecutive cycles, with select 0..15.
  - Then IDLE; no timeout_pulse.
- Timeout with TIMEOUT=15: unicast to lane 4 with out_ready[4]=0 held.
  - Expect timeout_pulse on the 15th SEND cycle, then IDLE.
  - With the macro defined, drop_cnt=1.
- Broadcast with a stall: out_ready[7]=0, all other lanes ready.
  - Expect exactly one timeout_pulse while select=7, all other lanes served, and a final return to IDLE.
- Reset mid-operation: assert rst while select=5 during a broadcast.
  - Expect out_valid=0, select=0, busy=0 the next cycle.
  - A new unicast to lane 2 then completes normally.
- Saturation (macro defined): force 300 timeouts.
  - Expect drop_cnt=255.
  - Assert drop_clr together with a timeout_pulse; expect drop_cnt=0.
